// File: rtl/avalon_csr_slave.sv
// Avalon-MM CSR bank: NUM_REGS words with byte-enable writes, fixed-latency pipelined reads
// and a write stall that keeps read and write responses off the shared response port together.
module avalon_csr_slave #(
    parameter int                     AWIDTH     = 20,
    parameter int                     DWIDTH     = 64,
    parameter int                     BE_WIDTH   = DWIDTH / 8,
    parameter int                     NUM_REGS   = 16,
    parameter logic [NUM_REGS-1:0]    RO_MASK    = '0,
    parameter int                     RD_LATENCY = 2,
    parameter logic [AWIDTH-1:0]      BASE_ADDR  = '0
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic [AWIDTH-1:0]            addr,
    input  logic [BE_WIDTH-1:0]          byte_enable,
    input  logic [DWIDTH-1:0]            wdata,
    input  logic                         wr,
    input  logic                         rd,
    output logic                         wait_request,
    output logic [DWIDTH-1:0]            rdata,
    output logic                         rdata_valid,
    output logic                         wr_resp_valid,
    output logic [1:0]                   response,
    output logic [NUM_REGS*DWIDTH-1:0]   ctrl_q,
    input  logic [NUM_REGS*DWIDTH-1:0]   status_d,
    output logic [NUM_REGS-1:0]          wr_pulse
);

    typedef enum logic [1:0] {
        RESP_OKAY         = 2'd0,
        RESP_RESERVED     = 2'd1,
        RESP_SLAVE_ERROR  = 2'd2,
        RESP_DECODE_ERROR = 2'd3
    } response_te;

    localparam int BSH   = $clog2(BE_WIDTH);
    localparam int IDX_W = (NUM_REGS > 1) ? $clog2(NUM_REGS) : 1;

    if (!(DWIDTH == 8 || DWIDTH == 16 || DWIDTH == 32 || DWIDTH == 64 || DWIDTH == 128)) begin : g_bad_dwidth
        $fatal(1, "avalon_csr_slave: DWIDTH must be 8/16/32/64/128");
    end
    if (BE_WIDTH != DWIDTH / 8) begin : g_bad_be
        $fatal(1, "avalon_csr_slave: BE_WIDTH must equal DWIDTH/8");
    end
    if (NUM_REGS < 1 || NUM_REGS > 256) begin : g_bad_regs
        $fatal(1, "avalon_csr_slave: NUM_REGS must be 1..256");
    end
    if (RD_LATENCY < 1 || RD_LATENCY > 4) begin : g_bad_lat
        $fatal(1, "avalon_csr_slave: RD_LATENCY must be 1..4");
    end
    if ((BASE_ADDR % BE_WIDTH) != 0) begin : g_bad_base
        $fatal(1, "avalon_csr_slave: BASE_ADDR must be word aligned");
    end

    logic [DWIDTH-1:0] regs [NUM_REGS];
    logic              init_stall;
    logic [AWIDTH-1:0] offset;
    logic [AWIDTH-1:0] word;
    logic [IDX_W-1:0]  sel;
    logic              dec_err;
    logic [DWIDTH-1:0] rd_word;
    logic [DWIDTH-1:0] wmask;
    logic              rd_acc;
    logic              wr_acc;
    logic              rd_due_next;

    logic              pipe_v    [RD_LATENCY];
    logic [DWIDTH-1:0] pipe_data [RD_LATENCY];
    response_te        pipe_resp [RD_LATENCY];
    logic              wr_resp_q;
    response_te        wr_resp_code;

    // Only the RO slices of status_d are consumed; fold the rest so nothing dangles.
    logic unused_status;
    assign unused_status = ^status_d;

    always_comb begin
        offset  = addr - BASE_ADDR;
        word    = offset >> BSH;
        sel     = word[IDX_W-1:0];
        dec_err = (addr < BASE_ADDR) || (word >= AWIDTH'(NUM_REGS));
        rd_word = dec_err ? '0 : regs[sel];
        for (int b = 0; b < BE_WIDTH; b++) begin
            wmask[b*8 +: 8] = {8{byte_enable[b]}};
        end
    end

    // A read whose response lands next cycle would collide with a write response.
    if (RD_LATENCY > 1) begin : g_hazard
        assign rd_due_next = pipe_v[RD_LATENCY-2];
    end else begin : g_no_hazard
        assign rd_due_next = 1'b0;
    end

    assign wait_request = init_stall | (wr & ~rd & rd_due_next);
    assign rd_acc       = rd & ~wait_request;
    assign wr_acc       = wr & ~rd & ~wait_request;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            init_stall   <= 1'b1;
            wr_resp_q    <= 1'b0;
            wr_resp_code <= RESP_OKAY;
            wr_pulse     <= '0;
            for (int i = 0; i < NUM_REGS; i++) begin
                regs[i] <= '0;
            end
            for (int k = 0; k < RD_LATENCY; k++) begin
                pipe_v[k]    <= 1'b0;
                pipe_data[k] <= '0;
                pipe_resp[k] <= RESP_OKAY;
            end
        end else begin
            init_stall <= 1'b0;
            for (int i = 0; i < NUM_REGS; i++) begin
                if (RO_MASK[i]) begin
                    regs[i] <= status_d[i*DWIDTH +: DWIDTH];
                end else if (wr_acc && !dec_err && sel == IDX_W'(i)) begin
                    regs[i] <= (regs[i] & ~wmask) | (wdata & wmask);
                end
                wr_pulse[i] <= wr_acc && !dec_err && !RO_MASK[i] && (sel == IDX_W'(i)) && (|byte_enable);
            end

            wr_resp_q <= wr_acc;
            if (!wr_acc)
                wr_resp_code <= RESP_OKAY;
            else if (dec_err)
                wr_resp_code <= RESP_DECODE_ERROR;
            else if (RO_MASK[sel])
                wr_resp_code <= RESP_SLAVE_ERROR;
            else
                wr_resp_code <= RESP_OKAY;

            // Stage data and response are zeroed when empty so outputs read 0 between strobes.
            pipe_v[0]    <= rd_acc;
            pipe_data[0] <= rd_acc ? rd_word : '0;
            if (!rd_acc)
                pipe_resp[0] <= RESP_OKAY;
            else if (dec_err)
                pipe_resp[0] <= RESP_DECODE_ERROR;
            else if (wr)
                pipe_resp[0] <= RESP_SLAVE_ERROR;
            else
                pipe_resp[0] <= RESP_OKAY;
            for (int k = 1; k < RD_LATENCY; k++) begin
                pipe_v[k]    <= pipe_v[k-1];
                pipe_data[k] <= pipe_data[k-1];
                pipe_resp[k] <= pipe_resp[k-1];
            end
        end
    end

    always_comb begin
        rdata_valid   = pipe_v[RD_LATENCY-1];
        rdata         = pipe_data[RD_LATENCY-1];
        wr_resp_valid = wr_resp_q;
        if (pipe_v[RD_LATENCY-1])
            response = pipe_resp[RD_LATENCY-1];
        else if (wr_resp_q)
            response = wr_resp_code;
        else
            response = RESP_OKAY;
        for (int i = 0; i < NUM_REGS; i++) begin
            ctrl_q[i*DWIDTH +: DWIDTH] = regs[i];
        end
    end

endmodule
